// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline with perf counters
module pipeline_hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_Ra,
  input  logic [4:0]       id_Rb,
  input  logic             id_uses_Ra,
  input  logic             id_uses_Rb,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_Rw,
  input  logic             mem_br_taken,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  localparam logic [2:0]       LU_INIT = 3'(LU_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, state_nxt, ret_state, ret_nxt, cur;
  logic [2:0] bubble_cnt, bubble_nxt;
  logic       hazard, stall_inc, flush_inc;

  always_comb begin
    // MEM_WAIT behaves as the state it froze, so a busy drop resumes in the same cycle
    cur = (state == MEM_WAIT) ? ret_state : state;
    hazard = ex_MemRead && (ex_Rw != 5'd31) &&
             ((id_uses_Ra && (id_Ra == ex_Rw)) || (id_uses_Rb && (id_Rb == ex_Rw)));

    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    state_nxt     = state;
    ret_nxt       = ret_state;
    bubble_nxt    = bubble_cnt;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    if (!reset) begin
      state_nxt = RUN;
    end else if (dmem_busy) begin
      state_nxt = MEM_WAIT;
      ret_nxt   = cur;
      stall_inc = 1'b1;
    end else if (mem_br_taken) begin
      pc_en         = 1'b1;
      pc_sel_branch = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
      ex_mem_en     = 1'b1;
      mem_wb_en     = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
      state_nxt     = RUN;
      bubble_nxt    = 3'd0;
      flush_inc     = 1'b1;
    end else if ((cur == LU_STALL) || hazard) begin
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      stall_inc   = 1'b1;
      if (cur == LU_STALL) begin
        bubble_nxt = bubble_cnt - 3'd1;
        state_nxt  = (bubble_cnt <= 3'd1) ? RUN : LU_STALL;
      end else if (LU_BUBBLES > 1) begin
        state_nxt  = LU_STALL;
        bubble_nxt = LU_INIT;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RUN;
      ret_state    <= RUN;
      bubble_cnt   <= 3'd0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state      <= state_nxt;
      ret_state  <= ret_nxt;
      bubble_cnt <= bubble_nxt;
      if (stall_inc && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_ONE;
      if (flush_inc && (flush_events != '1)) flush_events <= flush_events + CNT_ONE;
    end
  end

endmodule
